// File: rtl/intt_sched_pkg.sv
// intt_sched_pkg: shared types and constants for the Kyber inverse-NTT
// scheduler.
//   KYBER_Q        Kyber modulus. Coefficients are carried as-is and never reduced.
//   N_COEFF        number of coefficients in one vector.
//   COEFF_W        width of one coefficient.
//   coeff_t        a single coefficient.
//   coeff_vec_t    packed 8-coefficient vector. Element [0] is the first coefficient.
//   sched_state_t  scheduler state (IDLE, ACTIVE, DRAIN).
package intt_sched_pkg;
    localparam int KYBER_Q = 3329;
    localparam int N_COEFF = 8;
    localparam int COEFF_W = 12;

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef coeff_t [N_COEFF-1:0] coeff_vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } sched_state_t;
endpackage

// File: rtl/intt_sched_if.sv
// intt_sched_if: bundles the request, pipeline and response signals of the
// inverse-NTT scheduler.
//   slave  : scheduler view.
//   master : environment view (clients plus the Full_iNTT pipeline).
// Signals:
//   req_valid/req_ready           per-requester handshake.
//   req_coeffs0/1                 request vectors.
//   flush                         level input; stop accepting and drain.
//   intt_valid_in/intt_coeffs     issue toward Full_iNTT.
//   intt_valid_out/intt_coeffs_out  result from Full_iNTT.
//   rsp_valid/rsp_coeffs          one-hot routed response.
//   busy, err_orphan              status outputs.
interface intt_sched_if;
    import intt_sched_pkg::*;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    coeff_vec_t req_coeffs0;
    coeff_vec_t req_coeffs1;
    logic       flush;
    logic       intt_valid_in;
    coeff_vec_t intt_coeffs;
    logic       intt_valid_out;
    coeff_vec_t intt_coeffs_out;
    logic [1:0] rsp_valid;
    coeff_vec_t rsp_coeffs;
    logic       busy;
    logic       err_orphan;

    modport slave (
        input  req_valid, req_coeffs0, req_coeffs1, flush,
               intt_valid_out, intt_coeffs_out,
        output req_ready, intt_valid_in, intt_coeffs,
               rsp_valid, rsp_coeffs, busy, err_orphan
    );

    modport master (
        output req_valid, req_coeffs0, req_coeffs1, flush,
               intt_valid_out, intt_coeffs_out,
        input  req_ready, intt_valid_in, intt_coeffs,
               rsp_valid, rsp_coeffs, busy, err_orphan
    );
endinterface

// File: rtl/intt_tag_fifo.sv
// intt_tag_fifo: 1-bit-wide, DEPTH-deep synchronous FIFO that holds the
// requester id of every vector in flight through Full_iNTT, in issue order.
//   clk, r      clock and asynchronous active-high reset (empties the FIFO).
//   push, din   write one tag.
//   pop         discard the head tag.
//   dout        head tag. It is valid while empty is low.
//   empty, full occupancy flags.
// Pushes while full and pops while empty are ignored.
module intt_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic r,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic empty,
    output logic full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/intt_sched.sv
// intt_sched: two-requester scheduler in front of the shared 8-point Kyber
// inverse-NTT pipeline (Full_iNTT).
//   clk, r  clock and asynchronous active-high reset.
//   bus     intt_sched_if.slave: request handshakes, issue port, result port,
//           routed responses, busy and the sticky err_orphan flag.
// Accepted vectors are registered onto the issue port. The requester id is
// queued in intt_tag_fifo, and each returning result is steered back to the
// requester at the head of that queue. MAX_OUT bounds the number of vectors
// in flight.
// Build option INTT_SCHED_RR_EN: round-robin arbitration between the two
// requesters. Without it, requester 0 has fixed priority.
module intt_sched
    import intt_sched_pkg::*;
#(
    parameter int MAX_OUT = 8
) (
    input  logic   clk,
    input  logic   r,
    intt_sched_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             intt_valid_in_q, intt_valid_in_d;
    coeff_vec_t       intt_coeffs_q, intt_coeffs_d;
    logic             issue_tag_q, issue_tag_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    coeff_vec_t       rsp_coeffs_q, rsp_coeffs_d;
    logic             err_orphan_q, err_orphan_d;

    logic [1:0] grant;
    logic       accept, grant_id;
    logic       fifo_dout, fifo_empty, fifo_full;
    logic       pop, orphan;

`ifdef INTT_SCHED_RR_EN
    // Requester that wins the next two-way contention.
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = ~grant_id;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Grant decision. A flush in the current cycle already blocks grants,
    // one cycle before the state reaches DRAIN. A pop in the same cycle does
    // not free a credit for the requester.
    always_comb begin
        grant = 2'b00;
        if (!bus.flush && state_q != DRAIN && cnt_q != CNT_W'(MAX_OUT) && !fifo_full) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
`ifdef INTT_SCHED_RR_EN
                2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
`else
                2'b11:   grant = 2'b01;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept        = |grant;
    assign grant_id      = grant[1];
    assign bus.req_ready = grant;

    // The tag is pushed in the same cycle its vector is presented to Full_iNTT.
    intt_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
        .clk   (clk),
        .r     (r),
        .push  (intt_valid_in_q),
        .din   (issue_tag_q),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign pop    = bus.intt_valid_out & ~fifo_empty;
    assign orphan = bus.intt_valid_out & fifo_empty;

    always_comb begin
        // Orphans are not counted as pops, so cnt does not move below zero.
        cnt_d = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        intt_valid_in_d = accept;
        issue_tag_d     = accept ? grant_id : issue_tag_q;
        intt_coeffs_d   = intt_coeffs_q;
        if (accept) begin
            intt_coeffs_d = grant_id ? bus.req_coeffs1 : bus.req_coeffs0;
        end

        rsp_valid_d  = 2'b00;
        rsp_coeffs_d = rsp_coeffs_q;
        if (pop) begin
            rsp_valid_d[fifo_dout] = 1'b1;
            rsp_coeffs_d           = bus.intt_coeffs_out;
        end

        err_orphan_d = err_orphan_q | orphan;

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.flush)  state_d = DRAIN;
                else if (accept) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (bus.flush)          state_d = DRAIN;
                else if (cnt_d == '0)   state_d = IDLE;
            end
            DRAIN: begin
                if (!bus.flush && cnt_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            intt_valid_in_q <= 1'b0;
            intt_coeffs_q   <= '0;
            issue_tag_q     <= 1'b0;
            rsp_valid_q     <= 2'b00;
            rsp_coeffs_q    <= '0;
            err_orphan_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            intt_valid_in_q <= intt_valid_in_d;
            intt_coeffs_q   <= intt_coeffs_d;
            issue_tag_q     <= issue_tag_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_coeffs_q    <= rsp_coeffs_d;
            err_orphan_q    <= err_orphan_d;
        end
    end

    assign bus.intt_valid_in = intt_valid_in_q;
    assign bus.intt_coeffs   = intt_coeffs_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_coeffs    = rsp_coeffs_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.err_orphan    = err_orphan_q;
endmodule

// File: tb/tb_intt_sched.sv
// tb_intt_sched: bench for intt_sched. It pairs the design with a pass-through
// pipeline stub whose latency can be changed, and with a transaction-level
// reference model that follows the scheduler rules.
module tb_intt_sched;
    import intt_sched_pkg::*;

    localparam int MAX_OUT = 8;

    logic clk = 1'b0;
    logic r   = 1'b1;

    intt_sched_if vif();

    intt_sched #(.MAX_OUT(MAX_OUT)) dut (
        .clk (clk),
        .r   (r),
        .bus (vif)
    );

    always #5 clk = ~clk;

    // Pass-through stand-in for Full_iNTT: result appears stub_lat cycles after issue.
    logic [31:0] vpipe = '0;
    coeff_vec_t  dpipe [32];
    logic [4:0]  stub_lat = 5'd4;

    always @(posedge clk) begin
        vpipe    <= {vpipe[30:0], (vif.intt_valid_in === 1'b1)};
        dpipe[0] <= vif.intt_coeffs;
        for (int k = 1; k < 32; k++) dpipe[k] <= dpipe[k-1];
    end

    assign vif.intt_valid_out  = vpipe[stub_lat - 5'd1];
    assign vif.intt_coeffs_out = dpipe[stub_lat - 5'd1];

    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: outstanding list of accepted vectors in order.
    typedef struct packed {
        logic       id;
        coeff_vec_t data;
    } item_t;

    item_t      m_tags[$];
    int         m_cnt     = 0;
    int         m_state   = 0;     // 0 idle, 1 active, 2 drain
    int         m_last    = 1;     // requester granted last (1 => requester 0 favoured)
    logic       m_orphan  = 1'b0;
    logic       m_iss_due = 1'b0;
    coeff_vec_t m_iss_data = '0;
    logic       m_rsp_due = 1'b0;
    item_t      m_rsp     = '0;
    logic       mon_en    = 1'b0;

    function automatic logic [1:0] exp_ready(input logic [1:0] v, input logic fl);
        if (fl || m_state == 2 || m_cnt >= MAX_OUT) return 2'b00;
        if (v == 2'b11) begin
`ifdef INTT_SCHED_RR_EN
            return (m_last == 0) ? 2'b10 : 2'b01;
`else
            return 2'b01;
`endif
        end
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        logic [1:0] er;
        logic       acc, pop;
        int         cnt_before;
        item_t      it;
        if (mon_en) begin
            if (r) begin
                check("rst_intt_valid_in", vif.intt_valid_in, 1'b0);
                check("rst_rsp_valid", vif.rsp_valid, 2'b00);
                check("rst_busy", vif.busy, 1'b0);
                check("rst_err_orphan", vif.err_orphan, 1'b0);
                check("rst_intt_coeffs", vif.intt_coeffs, '0);
                check("rst_rsp_coeffs", vif.rsp_coeffs, '0);
                m_tags.delete();
                m_cnt = 0; m_state = 0; m_last = 1; m_orphan = 1'b0;
                m_iss_due = 1'b0; m_rsp_due = 1'b0;
            end else begin
                er = exp_ready(vif.req_valid, vif.flush);
                check("req_ready", vif.req_ready, er);
                check("intt_valid_in", vif.intt_valid_in, m_iss_due);
                if (m_iss_due) check("intt_coeffs", vif.intt_coeffs, m_iss_data);
                check("rsp_valid", vif.rsp_valid, m_rsp_due ? (2'b01 << m_rsp.id) : 2'b00);
                if (m_rsp_due) check("rsp_coeffs", vif.rsp_coeffs, m_rsp.data);
                check("busy", vif.busy, (m_state != 0));
                check("err_orphan", vif.err_orphan, m_orphan);

                acc = |(vif.req_valid & er);
                pop = vif.intt_valid_out && (m_tags.size() > 0);
                if (vif.intt_valid_out && m_tags.size() == 0) m_orphan = 1'b1;
                m_rsp_due = pop;
                if (pop) m_rsp = m_tags.pop_front();
                m_iss_due = acc;
                if (acc) begin
                    it.id   = er[1];
                    it.data = er[1] ? vif.req_coeffs1 : vif.req_coeffs0;
                    m_iss_data = it.data;
                    m_tags.push_back(it);
                    m_last = er[1] ? 1 : 0;
                end
                cnt_before = m_cnt;
                m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
                if (m_state == 0)      m_state = vif.flush ? 2 : (acc ? 1 : 0);
                else if (m_state == 1) m_state = vif.flush ? 2 : ((m_cnt == 0 && !acc) ? 0 : 1);
                else                   m_state = (!vif.flush && cnt_before == 0) ? 0 : 2;
            end
        end
    end

    // ------------------------------------------------------------------
    function automatic coeff_vec_t rand_vec();
        coeff_vec_t v;
        for (int i = 0; i < N_COEFF; i++) v[i] = coeff_t'($urandom_range(0, 4095));
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic fl, input coeff_vec_t c0, input coeff_vec_t c1);
        vif.req_valid   = v;
        vif.flush       = fl;
        vif.req_coeffs0 = c0;
        vif.req_coeffs1 = c1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        drive(2'b00, 1'b0, '0, '0);
        step();
        while ((vif.busy !== 1'b0 || m_tags.size() != 0 || m_rsp_due) && n < 300) begin
            step();
            n++;
        end
        check("drain_done", (n < 300), 1'b1);
    endtask

    task automatic set_lat(input logic [4:0] l);
        drive(2'b00, 1'b0, '0, '0);
        repeat (34) step();
        stub_lat = l;
    endtask

    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0] valid;
        logic       flush;
        logic [1:0] exp_fixed;
        logic [1:0] exp_rr;
    } row_t;

    row_t tbl [9];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_chk=%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : main
        coeff_vec_t v80, c0, c1, rc;
        logic [1:0] exp, rv, rdy;
        logic [1:0] cont_exp [6];
        int t_iss, t_rsp, cnt_a, cnt_b;
        logic seen_high, fl;

        tbl[0] = '{2'b00, 1'b0, 2'b00, 2'b00};
        tbl[1] = '{2'b01, 1'b0, 2'b01, 2'b01};
        tbl[2] = '{2'b10, 1'b0, 2'b10, 2'b10};
        tbl[3] = '{2'b11, 1'b0, 2'b01, 2'b01};
        tbl[4] = '{2'b11, 1'b0, 2'b01, 2'b10};
        tbl[5] = '{2'b11, 1'b0, 2'b01, 2'b01};
        tbl[6] = '{2'b11, 1'b1, 2'b00, 2'b00};
        tbl[7] = '{2'b11, 1'b0, 2'b00, 2'b00};
        tbl[8] = '{2'b00, 1'b0, 2'b00, 2'b00};

        for (int i = 0; i < N_COEFF; i++) v80[i] = coeff_t'(10 * (i + 1));

        // Reset.
        drive(2'b00, 1'b0, '0, '0);
        r = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        step();
        r = 1'b0;
        step();

        // Table: arbitration, flush blocking, drain blocking.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].valid, tbl[i].flush, rand_vec(), rand_vec());
            @(negedge clk);
`ifdef INTT_SCHED_RR_EN
            exp = tbl[i].exp_rr;
`else
            exp = tbl[i].exp_fixed;
`endif
            check($sformatf("table_row%0d_ready", i), vif.req_ready, exp);
            step();
        end
        wait_idle();

        // Single request from requester 1, latency 4.
        drive(2'b10, 1'b0, rand_vec(), v80);
        t_iss = -1; t_rsp = -1; rv = 2'b00; rc = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (vif.intt_valid_in === 1'b1 && t_iss < 0) t_iss = cyc;
            if (vif.rsp_valid !== 2'b00 && t_rsp < 0) begin
                t_rsp = cyc; rv = vif.rsp_valid; rc = vif.rsp_coeffs;
            end
            step();
            drive(2'b00, 1'b0, '0, '0);
        end
        check("single_issue_cycle", t_iss, 1);
        check("single_rsp_cycle", t_rsp, 6);
        check("single_rsp_valid", rv, 2'b10);
        check("single_rsp_coeffs", rc, v80);
        wait_idle();

        // Flush with three vectors in flight.
        cnt_a = 0; cnt_b = 0;
        for (int cyc = 0; cyc < 17; cyc++) begin
            if (cyc < 3)       drive(2'b01, 1'b0, rand_vec(), rand_vec());
            else if (cyc < 15) drive(2'b11, 1'b1, rand_vec(), rand_vec());
            else               drive(2'b00, 1'b0, '0, '0);
            @(negedge clk);
            if (cyc >= 3 && cyc < 15) begin
                if (vif.req_ready !== 2'b00) cnt_a++;
                if (vif.rsp_valid !== 2'b00) cnt_b++;
            end
            if (cyc == 14 || cyc == 15) check($sformatf("flush_busy_c%0d", cyc), vif.busy, 1'b1);
            if (cyc == 16) check("flush_busy_released", vif.busy, 1'b0);
            step();
        end
        check("flush_grants", cnt_a, 0);
        check("flush_responses", cnt_b, 3);
        wait_idle();

        // Reset mid-stream with two vectors inside the pipeline.
        drive(2'b01, 1'b0, rand_vec(), rand_vec());
        step();
        drive(2'b01, 1'b0, rand_vec(), rand_vec());
        step();
        drive(2'b00, 1'b0, '0, '0);
        step();
        r = 1'b1;
        #1;
        check("rstmid_busy", vif.busy, 1'b0);
        check("rstmid_intt_valid_in", vif.intt_valid_in, 1'b0);
        check("rstmid_intt_coeffs", vif.intt_coeffs, '0);
        check("rstmid_rsp_coeffs", vif.rsp_coeffs, '0);
        check("rstmid_rsp_valid", vif.rsp_valid, 2'b00);
        step();
        r = 1'b0;
        cnt_a = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (vif.rsp_valid !== 2'b00) cnt_a++;
            step();
        end
        check("rstmid_no_rsp", cnt_a, 0);
        check("rstmid_err_orphan", vif.err_orphan, 1'b1);

        // Contention from a fresh reset: both requesters valid for 6 cycles.
        r = 1'b1;
        step();
        r = 1'b0;
        step();
`ifdef INTT_SCHED_RR_EN
        cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 1'b0, rand_vec(), rand_vec());
            @(negedge clk);
            check($sformatf("contention_grant%0d", i), vif.req_ready, cont_exp[i]);
            step();
        end
        wait_idle();

        // Credit limit: latency 20, requester 0 always valid.
        set_lat(5'd20);
        cnt_a = 0; cnt_b = 0; seen_high = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            drive(2'b01, 1'b0, rand_vec(), rand_vec());
            @(negedge clk);
            rdy = vif.req_ready;
            if (cyc < 8 && rdy === 2'b01) cnt_a++;
            if (cyc >= 8 && !seen_high) begin
                if (rdy === 2'b00) cnt_b++;
                else seen_high = 1'b1;
            end
            step();
        end
        check("credit_first_grants", cnt_a, 8);
        check("credit_stall_cycles", cnt_b, 14);
        wait_idle();

        // Randomized traffic at two latencies.
        for (int ph = 0; ph < 2; ph++) begin
            set_lat(ph == 0 ? 5'd3 : 5'd9);
            fl = 1'b0;
            for (int cyc = 0; cyc < 300; cyc++) begin
                if (!fl && $urandom_range(0, 19) == 0) fl = 1'b1;
                else if (fl && $urandom_range(0, 3) == 0) fl = 1'b0;
                c0 = rand_vec();
                c1 = rand_vec();
                drive(2'(($urandom_range(0, 3))), fl, c0, c1);
                step();
            end
            wait_idle();
        end
        check("final_outstanding", m_tags.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
